// File: rtl/tcm_axi_master.sv
// AXI4 INCR burst initiator for TCM block copies: one burst outstanding, stream pass-through on W/R.
// Optional `TCM_AXI_MASTER_SPLIT_4K_EN keeps every burst inside a 4 KB page.
module tcm_axi_master (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [15:0] cmd_len_i,
    input  logic [31:0] src_data_i,
    input  logic [3:0]  src_strb_i,
    input  logic        src_valid_i,
    output logic        src_ready_o,
    output logic [31:0] dst_data_o,
    output logic        dst_valid_o,
    input  logic        dst_ready_i,
    output logic        done_o,
    output logic        done_err_o,
    output logic        busy_o,
    output logic        axi_awvalid_o,
    output logic [31:0] axi_awaddr_o,
    output logic [3:0]  axi_awid_o,
    output logic [7:0]  axi_awlen_o,
    output logic [1:0]  axi_awburst_o,
    input  logic        axi_awready_i,
    output logic        axi_wvalid_o,
    output logic [31:0] axi_wdata_o,
    output logic [3:0]  axi_wstrb_o,
    output logic        axi_wlast_o,
    input  logic        axi_wready_i,
    input  logic        axi_bvalid_i,
    input  logic [1:0]  axi_bresp_i,
    input  logic [3:0]  axi_bid_i,
    output logic        axi_bready_o,
    output logic        axi_arvalid_o,
    output logic [31:0] axi_araddr_o,
    output logic [3:0]  axi_arid_o,
    output logic [7:0]  axi_arlen_o,
    output logic [1:0]  axi_arburst_o,
    input  logic        axi_arready_i,
    input  logic        axi_rvalid_i,
    input  logic [31:0] axi_rdata_i,
    input  logic [1:0]  axi_rresp_i,
    input  logic [3:0]  axi_rid_i,
    input  logic        axi_rlast_i,
    output logic        axi_rready_o
);

    localparam logic [3:0] AXI_ID     = 4'd0;
    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] rem_q, rem_d;
    logic [8:0]  wcnt_q, wcnt_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic        done_err_q, done_err_d;

    logic [8:0]  beats;
    logic [7:0]  axlen;
    logic [31:0] addr_next;
    logic [15:0] rem_next;
    logic        err_acc;

    // Response IDs carry no information with a single outstanding transaction.
    logic unused_ok;
    assign unused_ok = ^{axi_bid_i, axi_rid_i};

`ifdef TCM_AXI_MASTER_SPLIT_4K_EN
    logic [12:0] page_lim;
    assign page_lim = (13'd4096 - {1'b0, addr_q[11:0]}) >> 2;
`endif

    always_comb begin
        beats = (rem_q > 16'd256) ? 9'd256 : rem_q[8:0];
`ifdef TCM_AXI_MASTER_SPLIT_4K_EN
        if ({4'd0, beats} > page_lim) begin
            beats = page_lim[8:0];
        end
`endif
    end

    // beats is never 0 in AW/AR, and 256 wraps to 0xFF as required.
    assign axlen     = beats[7:0] - 8'd1;
    assign addr_next = addr_q + {21'd0, beats, 2'b00};
    assign rem_next  = rem_q - {7'd0, beats};

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        wcnt_d        = wcnt_q;
        err_d         = err_q;
        done_d        = 1'b0;
        done_err_d    = 1'b0;
        err_acc       = err_q;
        cmd_ready_o   = 1'b0;
        src_ready_o   = 1'b0;
        dst_valid_o   = 1'b0;
        axi_awvalid_o = 1'b0;
        axi_awlen_o   = 8'd0;
        axi_wvalid_o  = 1'b0;
        axi_wlast_o   = 1'b0;
        axi_bready_o  = 1'b0;
        axi_arvalid_o = 1'b0;
        axi_arlen_o   = 8'd0;
        axi_rready_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    addr_d = {cmd_addr_i[31:2], 2'b00};
                    rem_d  = cmd_len_i;
                    err_d  = 1'b0;
                    wcnt_d = 9'd0;
                    if (cmd_len_i == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = cmd_write_i ? S_AW : S_AR;
                    end
                end
            end
            S_AW: begin
                axi_awvalid_o = 1'b1;
                axi_awlen_o   = axlen;
                if (axi_awready_i) begin
                    state_d = S_W;
                end
            end
            S_W: begin
                axi_wvalid_o = src_valid_i;
                src_ready_o  = axi_wready_i;
                axi_wlast_o  = (wcnt_q == beats - 9'd1);
                if (src_valid_i && axi_wready_i) begin
                    if (axi_wlast_o) begin
                        wcnt_d  = 9'd0;
                        state_d = S_B;
                    end else begin
                        wcnt_d = wcnt_q + 9'd1;
                    end
                end
            end
            S_B: begin
                axi_bready_o = 1'b1;
                if (axi_bvalid_i) begin
                    err_acc = err_q | (axi_bresp_i != 2'b00);
                    err_d   = err_acc;
                    addr_d  = addr_next;
                    rem_d   = rem_next;
                    if (rem_next == 16'd0) begin
                        state_d    = S_IDLE;
                        done_d     = 1'b1;
                        done_err_d = err_acc;
                    end else begin
                        state_d = S_AW;
                    end
                end
            end
            S_AR: begin
                axi_arvalid_o = 1'b1;
                axi_arlen_o   = axlen;
                if (axi_arready_i) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                dst_valid_o  = axi_rvalid_i;
                axi_rready_o = dst_ready_i;
                if (axi_rvalid_i && dst_ready_i) begin
                    err_acc = err_q | (axi_rresp_i != 2'b00);
                    err_d   = err_acc;
                    if (axi_rlast_i) begin
                        addr_d = addr_next;
                        rem_d  = rem_next;
                        if (rem_next == 16'd0) begin
                            state_d    = S_IDLE;
                            done_d     = 1'b1;
                            done_err_d = err_acc;
                        end else begin
                            state_d = S_AR;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            addr_q     <= 32'd0;
            rem_q      <= 16'd0;
            wcnt_q     <= 9'd0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            done_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            wcnt_q     <= wcnt_d;
            err_q      <= err_d;
            done_q     <= done_d;
            done_err_q <= done_err_d;
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign done_err_o    = done_err_q;
    assign axi_awaddr_o  = addr_q;
    assign axi_awid_o    = AXI_ID;
    assign axi_awburst_o = BURST_INCR;
    assign axi_wdata_o   = src_data_i;
    assign axi_wstrb_o   = src_strb_i;
    assign axi_araddr_o  = addr_q;
    assign axi_arid_o    = AXI_ID;
    assign axi_arburst_o = BURST_INCR;
    assign dst_data_o    = axi_rdata_i;

endmodule

// File: tb/tb_tcm_axi_master.sv
// Directed bench for tcm_axi_master: bench acts as AXI slave and stream endpoints.
module tb_tcm_axi_master;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_write_i = 1'b0;
    logic [31:0] cmd_addr_i = 32'd0;
    logic [15:0] cmd_len_i = 16'd0;
    logic [31:0] src_data_i = 32'd0;
    logic [3:0]  src_strb_i = 4'hF;
    logic        src_valid_i = 1'b0;
    logic        src_ready_o;
    logic [31:0] dst_data_o;
    logic        dst_valid_o;
    logic        dst_ready_i = 1'b1;
    logic        done_o, done_err_o, busy_o;
    logic        axi_awvalid_o;
    logic [31:0] axi_awaddr_o;
    logic [3:0]  axi_awid_o;
    logic [7:0]  axi_awlen_o;
    logic [1:0]  axi_awburst_o;
    logic        axi_awready_i = 1'b0;
    logic        axi_wvalid_o;
    logic [31:0] axi_wdata_o;
    logic [3:0]  axi_wstrb_o;
    logic        axi_wlast_o;
    logic        axi_wready_i = 1'b1;
    logic        axi_bvalid_i = 1'b0;
    logic [1:0]  axi_bresp_i = 2'b00;
    logic [3:0]  axi_bid_i = 4'd0;
    logic        axi_bready_o;
    logic        axi_arvalid_o;
    logic [31:0] axi_araddr_o;
    logic [3:0]  axi_arid_o;
    logic [7:0]  axi_arlen_o;
    logic [1:0]  axi_arburst_o;
    logic        axi_arready_i = 1'b0;
    logic        axi_rvalid_i = 1'b0;
    logic [31:0] axi_rdata_i = 32'd0;
    logic [1:0]  axi_rresp_i = 2'b00;
    logic [3:0]  axi_rid_i = 4'd0;
    logic        axi_rlast_i = 1'b0;
    logic        axi_rready_o;

    int n_cmp = 0;
    int n_bad = 0;

    tcm_axi_master dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .src_data_i(src_data_i), .src_strb_i(src_strb_i), .src_valid_i(src_valid_i),
        .src_ready_o(src_ready_o),
        .dst_data_o(dst_data_o), .dst_valid_o(dst_valid_o), .dst_ready_i(dst_ready_i),
        .done_o(done_o), .done_err_o(done_err_o), .busy_o(busy_o),
        .axi_awvalid_o(axi_awvalid_o), .axi_awaddr_o(axi_awaddr_o), .axi_awid_o(axi_awid_o),
        .axi_awlen_o(axi_awlen_o), .axi_awburst_o(axi_awburst_o), .axi_awready_i(axi_awready_i),
        .axi_wvalid_o(axi_wvalid_o), .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o),
        .axi_wlast_o(axi_wlast_o), .axi_wready_i(axi_wready_i),
        .axi_bvalid_i(axi_bvalid_i), .axi_bresp_i(axi_bresp_i), .axi_bid_i(axi_bid_i),
        .axi_bready_o(axi_bready_o),
        .axi_arvalid_o(axi_arvalid_o), .axi_araddr_o(axi_araddr_o), .axi_arid_o(axi_arid_o),
        .axi_arlen_o(axi_arlen_o), .axi_arburst_o(axi_arburst_o), .axi_arready_i(axi_arready_i),
        .axi_rvalid_i(axi_rvalid_i), .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i),
        .axi_rid_i(axi_rid_i), .axi_rlast_i(axi_rlast_i), .axi_rready_o(axi_rready_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [15:0] l,
                            input string tag);
        cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = a; cmd_len_i = l;
        #1 chk({tag, "_cmd_ready"}, 32'(cmd_ready_o), 32'd1);
        tick();
        cmd_valid_i = 1'b0;
        if (l != 16'd0)
            chk({tag, "_axvalid_next"}, 32'(wr ? axi_awvalid_o : axi_arvalid_o), 32'd1);
    endtask

    task automatic aw_hs(input logic [31:0] ea, input logic [7:0] el, input string tag);
        int n = 0;
        while (axi_awvalid_o !== 1'b1 && n < 20) begin tick(); n++; end
        chk({tag, "_awvalid"}, 32'(axi_awvalid_o), 32'd1);
        chk({tag, "_awaddr"}, axi_awaddr_o, ea);
        chk({tag, "_awlen"}, 32'(axi_awlen_o), 32'(el));
        chk({tag, "_awburst"}, 32'(axi_awburst_o), 32'd1);
        chk({tag, "_src_ready_outside_w"}, 32'(src_ready_o), 32'd0);
        axi_awready_i = 1'b1;
        tick();
        axi_awready_i = 1'b0;
    endtask

    task automatic w_beats(input int n, input logic [31:0] start, input logic [31:0] step,
                           input string tag);
        for (int i = 0; i < n; i++) begin
            src_valid_i = 1'b1;
            src_data_i  = start + 32'(i) * step;
            #1;
            chk({tag, "_wdata"}, axi_wdata_o, start + 32'(i) * step);
            chk({tag, "_wlast"}, 32'(axi_wlast_o), 32'(i == n - 1));
            tick();
        end
        src_valid_i = 1'b0;
    endtask

    task automatic b_hs(input logic [1:0] resp, input logic last, input logic exp_err,
                        input string tag);
        axi_bvalid_i = 1'b1; axi_bresp_i = resp;
        #1;
        chk({tag, "_bready"}, 32'(axi_bready_o), 32'd1);
        chk({tag, "_done_early"}, 32'(done_o), 32'd0);
        tick();
        axi_bvalid_i = 1'b0; axi_bresp_i = 2'b00;
        if (last) begin
            chk({tag, "_done"}, 32'(done_o), 32'd1);
            chk({tag, "_done_err"}, 32'(done_err_o), 32'(exp_err));
            chk({tag, "_cmd_ready_at_done"}, 32'(cmd_ready_o), 32'd1);
            tick();
            chk({tag, "_done_one_cycle"}, 32'(done_o), 32'd0);
        end else begin
            chk({tag, "_next_awvalid"}, 32'(axi_awvalid_o), 32'd1);
        end
    endtask

    task automatic ar_hs(input logic [31:0] ea, input logic [7:0] el, input string tag);
        int n = 0;
        while (axi_arvalid_o !== 1'b1 && n < 20) begin tick(); n++; end
        chk({tag, "_arvalid"}, 32'(axi_arvalid_o), 32'd1);
        chk({tag, "_araddr"}, axi_araddr_o, ea);
        chk({tag, "_arlen"}, 32'(axi_arlen_o), 32'(el));
        axi_rvalid_i = 1'b1;
        #1 chk({tag, "_dst_valid_outside_r"}, 32'(dst_valid_o), 32'd0);
        axi_rvalid_i = 1'b0;
        axi_arready_i = 1'b1;
        tick();
        axi_arready_i = 1'b0;
    endtask

    task automatic r_beats(input int n, input logic [31:0] start, input logic last,
                           input string tag);
        for (int i = 0; i < n; i++) begin
            axi_rvalid_i = 1'b1;
            axi_rdata_i  = start + 32'(i);
            axi_rlast_i  = (i == n - 1);
            #1;
            chk({tag, "_dst_data"}, dst_data_o, start + 32'(i));
            tick();
        end
        axi_rvalid_i = 1'b0; axi_rlast_i = 1'b0;
        if (last) begin
            chk({tag, "_done"}, 32'(done_o), 32'd1);
            chk({tag, "_done_err"}, 32'(done_err_o), 32'd0);
            tick();
            chk({tag, "_done_one_cycle"}, 32'(done_o), 32'd0);
        end else begin
            chk({tag, "_next_arvalid"}, 32'(axi_arvalid_o), 32'd1);
            chk({tag, "_no_mid_done"}, 32'(done_o), 32'd0);
        end
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_valids", {28'd0, axi_awvalid_o, axi_wvalid_o, axi_arvalid_o, axi_wlast_o}, 32'd0);
        chk("rst_readies", {30'd0, axi_bready_o, axi_rready_o}, 32'd0);
        chk("rst_done", {30'd0, done_o, done_err_o}, 32'd0);
        chk("rst_awaddr", axi_awaddr_o, 32'd0);
        chk("rst_lens", {16'd0, axi_awlen_o, axi_arlen_o}, 32'd0);
        chk("rst_ids", {24'd0, axi_awid_o, axi_arid_o}, 32'd0);
        chk("rst_bursts", {28'd0, axi_awburst_o, axi_arburst_o}, 32'h5);
        tick();
        rst_ni = 1'b1;
        tick();

        // 4-beat write
        send_cmd(1'b1, 32'h4000, 16'd4, "wr4");
        chk("wr4_busy", 32'(busy_o), 32'd1);
        aw_hs(32'h4000, 8'd3, "wr4");
        w_beats(4, 32'h11, 32'h11, "wr4");
        b_hs(2'b00, 1'b1, 1'b0, "wr4");

        // 300-beat read split at 256
        send_cmd(1'b0, 32'h8000, 16'd300, "rd300");
        ar_hs(32'h8000, 8'd255, "rd300a");
        r_beats(256, 32'h1000, 1'b0, "rd300a");
        ar_hs(32'h8400, 8'd43, "rd300b");
        r_beats(44, 32'h1100, 1'b1, "rd300b");

        // 4 KB boundary
        send_cmd(1'b1, 32'h4FF8, 16'd8, "split");
`ifdef TCM_AXI_MASTER_SPLIT_4K_EN
        aw_hs(32'h4FF8, 8'd1, "split_a");
        w_beats(2, 32'h500, 32'd1, "split_a");
        b_hs(2'b00, 1'b0, 1'b0, "split_a");
        aw_hs(32'h5000, 8'd5, "split_b");
        w_beats(6, 32'h502, 32'd1, "split_b");
        b_hs(2'b00, 1'b1, 1'b0, "split_b");
`else
        aw_hs(32'h4FF8, 8'd7, "split");
        w_beats(8, 32'h500, 32'd1, "split");
        b_hs(2'b00, 1'b1, 1'b0, "split");
`endif

        // Write backpressure: source stalls 3 cycles after beat 1
        send_cmd(1'b1, 32'h0103, 16'd4, "wbp");
        aw_hs(32'h0100, 8'd3, "wbp");
        for (int i = 0; i < 2; i++) begin
            src_valid_i = 1'b1; src_data_i = 32'hC0 + 32'(i);
            tick();
        end
        src_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("wbp_wvalid_stall", 32'(axi_wvalid_o), 32'd0);
            tick();
        end
        for (int i = 2; i < 4; i++) begin
            src_valid_i = 1'b1; src_data_i = 32'hC0 + 32'(i);
            #1;
            chk("wbp_wvalid", 32'(axi_wvalid_o), 32'd1);
            chk("wbp_wdata", axi_wdata_o, 32'hC0 + 32'(i));
            chk("wbp_wlast", 32'(axi_wlast_o), 32'(i == 3));
            tick();
        end
        src_valid_i = 1'b0;
        b_hs(2'b00, 1'b1, 1'b0, "wbp");

        // Read backpressure: sink stalls 2 cycles on the first beat
        send_cmd(1'b0, 32'h0200, 16'd2, "rbp");
        ar_hs(32'h0200, 8'd1, "rbp");
        axi_rvalid_i = 1'b1; axi_rdata_i = 32'hA0; dst_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("rbp_rready_low", 32'(axi_rready_o), 32'd0);
            chk("rbp_dst_valid", 32'(dst_valid_o), 32'd1);
            chk("rbp_dst_hold", dst_data_o, 32'hA0);
            tick();
        end
        dst_ready_i = 1'b1;
        #1 chk("rbp_rready_high", 32'(axi_rready_o), 32'd1);
        tick();
        axi_rdata_i = 32'hB0; axi_rlast_i = 1'b1;
        #1 chk("rbp_beat2", dst_data_o, 32'hB0);
        tick();
        axi_rvalid_i = 1'b0; axi_rlast_i = 1'b0;
        chk("rbp_done", 32'(done_o), 32'd1);
        tick();

        // Error on first burst does not abort
        send_cmd(1'b1, 32'h0, 16'd512, "err");
        aw_hs(32'h0, 8'd255, "err_a");
        w_beats(256, 32'h0, 32'd1, "err_a");
        b_hs(2'b10, 1'b0, 1'b0, "err_a");
        aw_hs(32'h400, 8'd255, "err_b");
        w_beats(256, 32'h100, 32'd1, "err_b");
        b_hs(2'b00, 1'b1, 1'b1, "err_b");

        // Length-0 command
        send_cmd(1'b1, 32'h1234, 16'd0, "len0");
        chk("len0_done", 32'(done_o), 32'd1);
        chk("len0_err", 32'(done_err_o), 32'd0);
        chk("len0_no_valid", {30'd0, axi_awvalid_o, axi_arvalid_o}, 32'd0);
        chk("len0_busy", 32'(busy_o), 32'd0);
        tick();
        chk("len0_done_one_cycle", 32'(done_o), 32'd0);

        // Reset during W beat 2
        send_cmd(1'b1, 32'h0300, 16'd4, "rstw");
        aw_hs(32'h0300, 8'd3, "rstw");
        for (int i = 0; i < 2; i++) begin
            src_valid_i = 1'b1; src_data_i = 32'hD0 + 32'(i);
            tick();
        end
        src_data_i = 32'hD2;
        #1 chk("rstw_wvalid_before", 32'(axi_wvalid_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("rstw_valids", {29'd0, axi_awvalid_o, axi_wvalid_o, axi_arvalid_o}, 32'd0);
        chk("rstw_src_ready", 32'(src_ready_o), 32'd0);
        chk("rstw_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("rstw_busy", 32'(busy_o), 32'd0);
        src_valid_i = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        chk("rstw_cmd_ready_after", 32'(cmd_ready_o), 32'd1);
        send_cmd(1'b0, 32'h0040, 16'd1, "post_rst");
        ar_hs(32'h0040, 8'd0, "post_rst");
        r_beats(1, 32'h77, 1'b1, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tcm_axi_master.md
# tcm_axi_master

AXI4 burst initiator that drives the TCM external AXI slave port, or any AXI4 slave on the same interconnect, from a simple command/stream interface. It is used by the boot loader and debug paths to block-copy words into and out of TCM. Each command is split into INCR bursts, with one burst outstanding at a time. Write data is taken from a source stream, read data is delivered to a sink stream, and a one-cycle done/error report is raised at the end of every command.

## Interface
- AXI_ID, 4'd0: value driven on axi_awid_o and axi_arid_o; the bid/rid response IDs are ignored.
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  in/out: out  1  high only in IDLE.
- cmd_write_i  in  1  1 = write (stream to AXI), 0 = read (AXI to stream).
- cmd_addr_i  in  32  byte address; bits [1:0] are ignored and forced to 0.
- cmd_len_i  in  16  length in 32-bit beats; 0 is legal and means no AXI traffic.
- src_data_i / src_strb_i / src_valid_i  in  32/4/1  write-data stream.
- src_ready_o  out  1  write-data stream accept.
- dst_data_o / dst_valid_o  out  32/1  read-data stream.
- dst_ready_i  in  1  read-data stream accept.
- done_o  out  1  one-cycle pulse when a command completes.
- done_err_o  out  1  valid with done_o; 1 if any response in the command was non-OKAY.
- busy_o  out  1  high whenever the block is not in IDLE.
- AW channel: axi_awvalid_o 1, axi_awaddr_o 32, axi_awid_o 4, axi_awlen_o 8, axi_awburst_o 2 (outputs); axi_awready_i 1 (input).
- W channel: axi_wvalid_o 1, axi_wdata_o 32, axi_wstrb_o 4, axi_wlast_o 1 (outputs); axi_wready_i 1 (input).
- B channel: axi_bvalid_i 1, axi_bresp_i 2, axi_bid_i 4 (inputs); axi_bready_o 1 (output).
- AR channel: axi_arvalid_o 1, axi_araddr_o 32, axi_arid_o 4, axi_arlen_o 8, axi_arburst_o 2 (outputs); axi_arready_i 1 (input).
- R channel: axi_rvalid_i 1, axi_rdata_i 32, axi_rresp_i 2, axi_rid_i 4, axi_rlast_i 1 (inputs); axi_rready_o 1 (output).

## Operation
- **States:** IDLE, AW, W, B, AR, R.
- **Command accept (IDLE):** on cmd_valid_i & cmd_ready_o, latch addr, remaining = cmd_len_i, and dir; clear the error flag.
  - len 0: go to IDLE and pulse done_o with done_err_o = 0.
  - Otherwise: go to AW (write) or AR (read).
- **Burst size:** beats = min(remaining, 256, boundary limit). axlen = beats-1. axburst = 2'b01 (INCR). axsize is implicitly 4 bytes.
- **AW/AR state:** axvalid held high with stable fields until ready.
  - AW then goes to W.
  - AR then goes to R.
- **W state (pass-through):**
  - axi_wvalid_o = src_valid_i.
  - src_ready_o = axi_wready_i.
  - wdata/wstrb are taken from src_*.
  - axi_wlast_o is high on beat number `beats`.
  - The wlast handshake moves to B.
- **B state:** axi_bready_o = 1. On the handshake:
  - OR (bresp != 0) into the error flag.
  - Update addr += beats*4 and remaining -= beats.
  - If remaining = 0, go to IDLE and pulse done; otherwise go to AW.
- **R state (pass-through):**
  - dst_valid_o = axi_rvalid_i.
  - axi_rready_o = dst_ready_i.
  - dst_data_o = axi_rdata_i.
  - OR (rresp != 0) into the error flag on every beat.
  - The rlast handshake updates addr/remaining as in B and goes to AR or IDLE.
- **Error response:** does not abort the command; the remaining bursts are still issued.
- **Stream signals outside their state:** src_ready_o and dst_valid_o are 0.
- **Address arithmetic:** 32-bit, wraps modulo 2^32 without a flag.

## Timing
- **Reset values (rst_ni low, asynchronous):**
  - State = IDLE.
  - cmd_ready_o = 1; busy_o = 0.
  - All axi_*valid_o, axi_wlast_o, axi_bready_o, axi_rready_o = 0.
  - done_o = 0, done_err_o = 0; all address/len fields = 0.
  - axi_awid_o/axi_arid_o = AXI_ID; axburst = 2'b01.
- **Reset mid-burst:** outputs drop immediately and the outstanding AXI transaction is abandoned. The system resets the slave together with this block.
- **Command to address phase:** accept in cycle N gives axvalid high in N+1.
- **Burst to burst:** B handshake or rlast in cycle N gives the next axvalid in N+1.
- **Done:** done_o is high in the cycle after the final B/rlast handshake, for exactly one cycle, with cmd_ready_o = 1 in that same cycle. A new command may be accepted in that cycle.
- **Length-0 command:** done_o in cycle N+1.
- **Throughput:** W/R beats sustain 1 per cycle under full valid/ready; there is no added bubble inside a burst.
- **Outstanding transactions:** exactly one.

## Configuration
- **TCM_AXI_MASTER_SPLIT_4K_EN defined:** boundary limit = (4096 - addr[11:0]) >> 2, so no burst crosses a 4 KB boundary.
- **TCM_AXI_MASTER_SPLIT_4K_EN undefined:** no boundary limit; bursts are bounded only by remaining and 256. The caller guarantees legality.

## Test plan
- **4-beat write:** write, addr 0x4000, len 4, src data 0x11,0x22,0x33,0x44 → awaddr 0x4000, awlen 3, awburst 01; four W beats with wlast on 0x44; bresp OKAY → done_o one cycle after B, done_err_o 0.
- **300-beat read:** read, addr 0x8000, len 300 → AR len 255 at 0x8000, then AR len 43 at 0x8400; exactly 300 dst beats in order; single done_o.
- **4 KB split:** write, addr 0x4FF8, len 8.
  - Macro on → bursts awlen 1 at 0x4FF8 and awlen 5 at 0x5000.
  - Macro off → single awlen 7 at 0x4FF8.
- **Backpressure:** src_valid_i low for 3 cycles mid-burst → wvalid low with no beat lost. dst_ready_i low → rready low and dst_data_o held.
- **Error report:** write len 512 with bresp 2'b10 on the first burst → second burst still issued; done_err_o = 1 with done_o. Also, len 0 → done_o in cycle N+1 with no AXI valid.
- **Reset mid-burst:** assert rst_ni low during W beat 2 → all valids 0 immediately; after release, cmd_ready_o = 1 and a new command completes normally.
